// File: rtl/mi_sram_resp_if.sv
// Initiator/responder bundle for the mi_* burst memory interface.
// MI_SRAM_RESP_WMSK_EN adds the per-beat byte mask mi_wmsk (1 = byte masked).
interface mi_sram_resp_if #(
  parameter int unsigned LEN_W = 7
);
  logic [23:0]      mi_addr;
  logic [LEN_W-1:0] mi_len;
  logic             mi_rw;
  logic             mi_valid;
  logic             mi_ready;
  logic [31:0]      mi_wdata;
  logic             mi_wack;
  logic             mi_wlast;
  logic [31:0]      mi_rdata;
  logic             mi_rstb;
  logic             mi_rlast;
`ifdef MI_SRAM_RESP_WMSK_EN
  logic [3:0]       mi_wmsk;

  modport master (
    output mi_addr, mi_len, mi_rw, mi_valid, mi_wdata, mi_wmsk,
    input  mi_ready, mi_wack, mi_wlast, mi_rdata, mi_rstb, mi_rlast
  );
  modport slave (
    input  mi_addr, mi_len, mi_rw, mi_valid, mi_wdata, mi_wmsk,
    output mi_ready, mi_wack, mi_wlast, mi_rdata, mi_rstb, mi_rlast
  );
`else
  modport master (
    output mi_addr, mi_len, mi_rw, mi_valid, mi_wdata,
    input  mi_ready, mi_wack, mi_wlast, mi_rdata, mi_rstb, mi_rlast
  );
  modport slave (
    input  mi_addr, mi_len, mi_rw, mi_valid, mi_wdata,
    output mi_ready, mi_wack, mi_wlast, mi_rdata, mi_rstb, mi_rlast
  );
`endif
endinterface

// File: rtl/mi_sram_resp.sv
// mi_* burst responder backed by a single-port word RAM with 1-cycle read latency.
// Define MI_SRAM_RESP_WMSK_EN to forward the initiator's byte mask to the RAM.
module mi_sram_resp #(
  parameter int unsigned AW    = 14,
  parameter int unsigned LEN_W = 7
) (
  input  logic           clk,
  input  logic           rst,
  mi_sram_resp_if.slave  mi,
  output logic [AW-1:0]  ram_addr,
  output logic [31:0]    ram_wdata,
  output logic [3:0]     ram_wmsk,
  output logic           ram_we,
  input  logic [31:0]    ram_rdata
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WR      = 2'd1;
  localparam logic [1:0] RD      = 2'd2;
  localparam logic [1:0] RD_TAIL = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             rstb_q;
  logic             accept;
  logic             last_beat;

  // Only the low AW address bits reach the RAM.
  logic unused_addr_hi;
  assign unused_addr_hi = ^mi.mi_addr[23:AW];

  assign accept    = mi.mi_valid & mi.mi_ready;
  assign last_beat = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = mi.mi_addr[AW-1:0];
          cnt_d   = mi.mi_len;
          state_d = mi.mi_rw ? RD : WR;
        end
      end
      WR: begin
        addr_d = addr_q + AW'(1);
        cnt_d  = cnt_q - LEN_W'(1);
        if (last_beat) state_d = IDLE;
      end
      RD: begin
        addr_d = addr_q + AW'(1);
        cnt_d  = cnt_q - LEN_W'(1);
        if (last_beat) state_d = RD_TAIL;
      end
      RD_TAIL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      rstb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      // Read data returns one cycle after the address is issued.
      rstb_q  <= (state_q == RD);
    end
  end

  assign mi.mi_ready = (state_q == IDLE) & ~rst;
  assign mi.mi_wack  = (state_q == WR);
  assign mi.mi_wlast = (state_q == WR) & last_beat;
  assign mi.mi_rstb  = rstb_q;
  assign mi.mi_rlast = rstb_q & (state_q == RD_TAIL);
  assign mi.mi_rdata = ram_rdata;

  assign ram_addr  = addr_q;
  assign ram_we    = (state_q == WR);
  assign ram_wdata = mi.mi_wdata;
`ifdef MI_SRAM_RESP_WMSK_EN
  assign ram_wmsk  = (state_q == WR) ? mi.mi_wmsk : 4'h0;
`else
  assign ram_wmsk  = 4'h0;
`endif

endmodule

// File: tb/tb_mi_sram_resp.sv
// Directed bench for mi_sram_resp with a behavioural 1-cycle-latency RAM.
// Covers bursts, wrap, max length, back-to-back, mid-burst reset and MI_SRAM_RESP_WMSK_EN.
module tb_mi_sram_resp;

  localparam int unsigned AW    = 14;
  localparam int unsigned LEN_W = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tb_init = 1'b1;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [3:0]    ram_wmsk;
  logic          ram_we;
  logic [31:0]   ram_rdata;

  logic [31:0]   mem [0:(1<<AW)-1];
  logic [31:0]   exp_data [0:127];

  int errors = 0;
  int checks = 0;

  mi_sram_resp_if #(.LEN_W(LEN_W)) mi ();

  mi_sram_resp #(.AW(AW), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mi        (mi),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_wmsk  (ram_wmsk),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Backing RAM: unwritten words hold 0x5A000000 | address.
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'h5A00_0000 | i;
    end else if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (!ram_wmsk[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat(input int a);
    return 32'h5A00_0000 | (a & ((1 << AW) - 1));
  endfunction

  task automatic issue(input logic [23:0] a, input int len, input bit rw, input bit keep);
    mi.mi_addr  = a;
    mi.mi_len   = LEN_W'(len);
    mi.mi_rw    = rw;
    mi.mi_valid = 1'b1;
    #1 chk("ready_at_accept", {31'd0, mi.mi_ready}, 32'd1);
    @(negedge clk);
    if (!keep) mi.mi_valid = 1'b0;
  endtask

  task automatic wr_burst(input logic [23:0] a, input int len, input logic [31:0] base,
                          input logic [3:0] msk);
    issue(a, len, 1'b0, 1'b0);
    for (int i = 0; i <= len; i++) begin
      mi.mi_wdata = base + i;
`ifdef MI_SRAM_RESP_WMSK_EN
      mi.mi_wmsk = msk;
`endif
      #1;
      chk("wack", {31'd0, mi.mi_wack}, 32'd1);
      chk("wlast", {31'd0, mi.mi_wlast}, {31'd0, i == len});
      chk("ram_we", {31'd0, ram_we}, 32'd1);
      chk("ram_addr_wr", {18'd0, ram_addr}, (a + i) & 32'h3FFF);
      chk("ram_wdata", ram_wdata, base + i);
`ifdef MI_SRAM_RESP_WMSK_EN
      chk("ram_wmsk", {28'd0, ram_wmsk}, {28'd0, msk});
`else
      chk("ram_wmsk", {28'd0, ram_wmsk}, {28'd0, msk & 4'h0});
`endif
      chk("ready_busy_wr", {31'd0, mi.mi_ready}, 32'd0);
      chk("rstb_in_wr", {31'd0, mi.mi_rstb}, 32'd0);
      @(negedge clk);
    end
    #1;
    chk("wack_end", {31'd0, mi.mi_wack}, 32'd0);
    chk("ready_after_wr", {31'd0, mi.mi_ready}, 32'd1);
  endtask

  // Compares against exp_data[0..len].
  task automatic rd_burst(input logic [23:0] a, input int len, input bit keep);
    issue(a, len, 1'b1, keep);
    #1 chk("rstb_latency", {31'd0, mi.mi_rstb}, 32'd0);
    @(negedge clk);
    for (int i = 0; i <= len; i++) begin
      #1;
      chk("rstb", {31'd0, mi.mi_rstb}, 32'd1);
      chk("rdata", mi.mi_rdata, exp_data[i]);
      chk("rlast", {31'd0, mi.mi_rlast}, {31'd0, i == len});
      chk("wack_in_rd", {31'd0, mi.mi_wack}, 32'd0);
      chk("ready_busy_rd", {31'd0, mi.mi_ready}, 32'd0);
      @(negedge clk);
    end
    #1;
    chk("rstb_end", {31'd0, mi.mi_rstb}, 32'd0);
    chk("rlast_end", {31'd0, mi.mi_rlast}, 32'd0);
    chk("ready_after_rd", {31'd0, mi.mi_ready}, 32'd1);
  endtask

  typedef struct {
    logic [23:0] addr;
    int          len;
    bit          rw;
    logic [31:0] base;
  } vec_t;

  initial begin
    vec_t vecs [0:7];
    vecs[0] = '{24'h000010, 3, 1'b0, 32'h0000_00A0};
    vecs[1] = '{24'h000010, 3, 1'b1, 32'h0000_00A0};
    vecs[2] = '{24'h000000, 0, 1'b0, 32'hDEAD_BEEF};
    vecs[3] = '{24'h000000, 0, 1'b1, 32'hDEAD_BEEF};
    vecs[4] = '{24'h003FFE, 3, 1'b0, 32'h0000_00C0};
    vecs[5] = '{24'h003FFE, 3, 1'b1, 32'h0000_00C0};
    vecs[6] = '{24'hAB0020, 1, 1'b0, 32'h0000_00E0};
    vecs[7] = '{24'h000020, 1, 1'b1, 32'h0000_00E0};

    mi.mi_addr  = '0;
    mi.mi_len   = '0;
    mi.mi_rw    = 1'b0;
    mi.mi_valid = 1'b0;
    mi.mi_wdata = '0;
`ifdef MI_SRAM_RESP_WMSK_EN
    mi.mi_wmsk  = 4'h0;
`endif

    // Reset state
    @(negedge clk);
    chk("rst_wack", {31'd0, mi.mi_wack}, 32'd0);
    chk("rst_wlast", {31'd0, mi.mi_wlast}, 32'd0);
    chk("rst_rstb", {31'd0, mi.mi_rstb}, 32'd0);
    chk("rst_rlast", {31'd0, mi.mi_rlast}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_wmsk", {28'd0, ram_wmsk}, 32'd0);
    tb_init = 1'b0;
    rst     = 1'b0;
    #1;
    chk("rst_ready", {31'd0, mi.mi_ready}, 32'd1);
    chk("rst_ram_addr", {18'd0, ram_addr}, 32'd0);
    @(negedge clk);

    // Table: writes then readbacks, single beat, wrap, high address bits ignored
    for (int v = 0; v < 8; v++) begin
      if (!vecs[v].rw) begin
        wr_burst(vecs[v].addr, vecs[v].len, vecs[v].base, 4'h0);
      end else begin
        for (int i = 0; i <= vecs[v].len; i++) exp_data[i] = vecs[v].base + i;
        rd_burst(vecs[v].addr, vecs[v].len, 1'b0);
      end
      @(negedge clk);
    end

    // Wrapped words landed at 0x0000/0x0001, overwriting the single-beat word
    for (int i = 0; i < 2; i++) exp_data[i] = 32'hC2 + i;
    rd_burst(24'h000000, 1, 1'b0);
    @(negedge clk);

    // Max burst with mi_valid held high, then back-to-back accept
    for (int i = 0; i < 128; i++) exp_data[i] = pat(32'h1000 + i);
    rd_burst(24'h001000, 127, 1'b1);
    for (int i = 0; i < 4; i++) exp_data[i] = 32'hA0 + i;
    rd_burst(24'h000010, 3, 1'b0);
    @(negedge clk);

    // Reset after 2 of 8 write beats
    issue(24'h000200, 7, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      mi.mi_wdata = 32'hB0 + i;
      @(negedge clk);
    end
    mi.mi_wdata = 32'hB2;
    rst = 1'b1;
    #1;
    chk("midrst_wack", {31'd0, mi.mi_wack}, 32'd0);
    chk("midrst_wlast", {31'd0, mi.mi_wlast}, 32'd0);
    chk("midrst_ram_we", {31'd0, ram_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("midrst_ready", {31'd0, mi.mi_ready}, 32'd1);
    @(negedge clk);
    exp_data[0] = 32'hB0;
    exp_data[1] = 32'hB1;
    for (int i = 2; i < 8; i++) exp_data[i] = pat(32'h200 + i);
    rd_burst(24'h000200, 7, 1'b0);
    @(negedge clk);

    // Byte mask 4'b0101 over an all-ones word
    wr_burst(24'h000300, 0, 32'hFFFF_FFFF, 4'h0);
    wr_burst(24'h000300, 0, 32'h1122_3344, 4'b0101);
    #1 chk("idle_ram_wmsk", {28'd0, ram_wmsk}, 32'd0);
`ifdef MI_SRAM_RESP_WMSK_EN
    exp_data[0] = 32'h11FF_33FF;
`else
    exp_data[0] = 32'h1122_3344;
`endif
    @(negedge clk);
    rd_burst(24'h000300, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
